// File: rtl/spi_master_gen.sv
// rtl/spi_master_gen.sv - parametrised SPI master: control FSM, SCK divider, full-duplex shifter, CS decode
//
// Ports:
//   Clk       system clock, all logic on its rising edge
//   Rst       synchronous active-high reset
//   StartTx   start request, honoured only while idle
//   TxData    word to send, latched with the accepted StartTx
//   CPol      SCK idle level
//   CPha      0: sample on leading edge, 1: sample on trailing edge
//   LsbFirst  1: bit 0 goes first, 0: bit DATA_W-1 goes first
//   Div       SCK half-period is Div+1 Clk cycles
//   CsSel     slave index; values >= NUM_CS select nothing
//   MISO      serial data in
//   SCK       serial clock (registered)
//   MOSI      serial data out (registered)
//   CS_n      active-low chip selects (registered)
//   Busy      high in every state except IDLE
//   EndTx     one-cycle completion pulse
//   RxData    last received word, held until the next EndTx
module spi_master_gen #(
  parameter int DATA_W   = 8,
  parameter int DIV_W    = 8,
  parameter int NUM_CS   = 4,
  parameter int CS_SEL_W = 2
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                StartTx,
  input  logic [DATA_W-1:0]   TxData,
  input  logic                CPol,
  input  logic                CPha,
  input  logic                LsbFirst,
  input  logic [DIV_W-1:0]    Div,
  input  logic [CS_SEL_W-1:0] CsSel,
  input  logic                MISO,
  output logic                SCK,
  output logic                MOSI,
  output logic [NUM_CS-1:0]   CS_n,
  output logic                Busy,
  output logic                EndTx,
  output logic [DATA_W-1:0]   RxData
);

  // One spare bit so the edge counter can reach 2*DATA_W without wrapping.
  localparam int BIT_W = $clog2(2 * DATA_W) + 1;
  localparam logic [BIT_W-1:0] LAST_EDGE = BIT_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    XFER  = 3'd2,
    TRAIL = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  half_cnt;
  logic [DIV_W-1:0]  div_r;
  logic [BIT_W-1:0]  edge_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              cpol_r;
  logic              cpha_r;
  logic              lsb_r;

  // Bit that leaves the transmit shifter next, depending on bit order.
  function automatic logic out_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  // Discard the bit just driven so the next one sits at the output end.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Received bits enter from the far end so that after DATA_W samples the
  // first bit lands in bit 0 (LSB first) or bit DATA_W-1 (MSB first).
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // One-cold decode; an out-of-range select leaves every line high.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_SEL_W-1:0] sel);
    logic [NUM_CS-1:0] cs;
    cs = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CS_SEL_W'(i)) cs[i] = 1'b0;
    end
    return cs;
  endfunction

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      half_cnt <= '0;
      div_r    <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
      lsb_r    <= 1'b0;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
      CS_n     <= '1;
      Busy     <= 1'b0;
      EndTx    <= 1'b0;
      RxData   <= '0;
    end else begin
      case (state)
        IDLE: begin
          SCK   <= CPol;
          MOSI  <= 1'b0;
          CS_n  <= '1;
          EndTx <= 1'b0;
          Busy  <= 1'b0;
          if (StartTx) begin
            state    <= LEAD;
            Busy     <= 1'b1;
            cpol_r   <= CPol;
            cpha_r   <= CPha;
            lsb_r    <= LsbFirst;
            div_r    <= Div;
            half_cnt <= '0;
            edge_cnt <= '0;
            rx_sh    <= '0;
            CS_n     <= cs_decode(CsSel);
            // CPha=0 puts the first bit out before the first (sampling) edge;
            // CPha=1 waits for the leading edge to drive it.
            if (CPha) begin
              MOSI  <= 1'b0;
              tx_sh <= TxData;
            end else begin
              MOSI  <= out_bit(TxData, LsbFirst);
              tx_sh <= shift_out(TxData, LsbFirst);
            end
          end
        end

        LEAD: begin
          SCK <= cpol_r;
          if (half_cnt == div_r) begin
            half_cnt <= '0;
            state    <= XFER;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end

        XFER: begin
          if (half_cnt == div_r) begin
            half_cnt <= '0;
            SCK      <= ~SCK;
            edge_cnt <= edge_cnt + 1'b1;
            // edge_cnt holds the edges already made, so an even count means
            // this toggle is a leading edge.
            if (!edge_cnt[0]) begin
              if (!cpha_r) begin
                rx_sh <= shift_in(rx_sh, MISO, lsb_r);
              end else begin
                MOSI  <= out_bit(tx_sh, lsb_r);
                tx_sh <= shift_out(tx_sh, lsb_r);
              end
            end else begin
              if (cpha_r) begin
                rx_sh <= shift_in(rx_sh, MISO, lsb_r);
              end else if (edge_cnt != LAST_EDGE) begin
                MOSI  <= out_bit(tx_sh, lsb_r);
                tx_sh <= shift_out(tx_sh, lsb_r);
              end
            end
            if (edge_cnt == LAST_EDGE) state <= TRAIL;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end

        TRAIL: begin
          SCK <= cpol_r;
          if (half_cnt == div_r) begin
            half_cnt <= '0;
            state    <= DONE;
            CS_n     <= '1;
            MOSI     <= 1'b0;
            EndTx    <= 1'b1;
            RxData   <= rx_sh;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end

        DONE: begin
          // StartTx is deliberately not looked at here.
          EndTx <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          EndTx <= 1'b0;
          CS_n  <= '1;
          MOSI  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_gen.sv
// tb/tb_spi_master_gen.sv - scoreboard bench for spi_master_gen with behavioural slave model
module tb_spi_master_gen;

  localparam int DATA_W   = 8;
  localparam int DIV_W    = 8;
  localparam int NUM_CS   = 4;
  localparam int CS_SEL_W = 3;

  logic                Clk = 1'b0;
  logic                Rst;
  logic                StartTx;
  logic [DATA_W-1:0]   TxData;
  logic                CPol;
  logic                CPha;
  logic                LsbFirst;
  logic [DIV_W-1:0]    Div;
  logic [CS_SEL_W-1:0] CsSel;
  logic                MISO = 1'b0;
  logic                SCK;
  logic                MOSI;
  logic [NUM_CS-1:0]   CS_n;
  logic                Busy;
  logic                EndTx;
  logic [DATA_W-1:0]   RxData;

  spi_master_gen #(
    .DATA_W  (DATA_W),
    .DIV_W   (DIV_W),
    .NUM_CS  (NUM_CS),
    .CS_SEL_W(CS_SEL_W)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .StartTx (StartTx),
    .TxData  (TxData),
    .CPol    (CPol),
    .CPha    (CPha),
    .LsbFirst(LsbFirst),
    .Div     (Div),
    .CsSel   (CsSel),
    .MISO    (MISO),
    .SCK     (SCK),
    .MOSI    (MOSI),
    .CS_n    (CS_n),
    .Busy    (Busy),
    .EndTx   (EndTx),
    .RxData  (RxData)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  int stray  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] slv;
    logic              cpol;
    logic              cpha;
    logic              lsb;
    logic              loop;
    int                div;
    logic [NUM_CS-1:0] cs_mask;
  } xfer_t;

  xfer_t sb_q[$];

  // Reference rules: CS, lead, 2*DATA_W half-periods and trail all last Div+1 cycles.
  function automatic int exp_latency(input int div);
    return (2 * DATA_W + 2) * (div + 1);
  endfunction

  function automatic logic [NUM_CS-1:0] exp_cs_mask(input int sel);
    return (sel < NUM_CS) ? NUM_CS'(1 << sel) : '0;
  endfunction

  // Monitor and slave model, acting on the falling edge.
  logic              prev_sck  = 1'b0;
  logic              prev_mosi = 1'b0;
  logic              prev_busy = 1'b0;
  int                edges     = 0;
  int                nsamp     = 0;
  int                rise_cyc  = 0;
  int                cs_low    = 0;
  logic [NUM_CS-1:0] cs_seen   = '0;
  logic [DATA_W-1:0] got_tx    = '0;
  xfer_t             cur;
  int                idx;

  always @(negedge Clk) begin
    if (Rst) begin
      edges   = 0;
      nsamp   = 0;
      cs_low  = 0;
      cs_seen = '0;
      got_tx  = '0;
    end else begin
      if (Busy && !prev_busy) begin
        rise_cyc = cyc;
        edges    = 0;
        nsamp    = 0;
        cs_low   = 0;
        cs_seen  = '0;
        got_tx   = '0;
      end
      if (Busy && prev_busy && (SCK !== prev_sck)) begin
        edges++;
        // Slave samples on odd (leading) edges for CPha=0, even for CPha=1.
        if (sb_q.size() > 0 && (((edges % 2) == 1) == (sb_q[0].cpha == 1'b0))) begin
          if (nsamp < DATA_W) begin
            if (sb_q[0].lsb) got_tx[nsamp] = prev_mosi;
            else             got_tx[DATA_W-1-nsamp] = prev_mosi;
          end
          nsamp++;
        end
      end
      if (Busy && !EndTx) begin
        cs_seen = cs_seen | ~CS_n;
        if (CS_n !== '1) cs_low++;
      end
      if (EndTx) begin
        if (sb_q.size() == 0) begin
          stray++;
        end else begin
          cur = sb_q.pop_front();
          check("rxdata",     RxData, cur.slv);
          check("mosi_word",  got_tx, cur.tx);
          check("latency",    cyc - rise_cyc, exp_latency(cur.div));
          check("sck_edges",  edges, 2 * DATA_W);
          check("cs_seen",    cs_seen, cur.cs_mask);
          check("cs_low_len", cs_low, (cur.cs_mask != 0) ? exp_latency(cur.div) : 0);
          check("done_sck",   SCK, cur.cpol);
          check("done_cs",    CS_n, {NUM_CS{1'b1}});
          check("done_mosi",  MOSI, 1'b0);
        end
      end
    end

    // Slave drives its next bit for the coming rising edge.
    if (sb_q.size() > 0) begin
      if (sb_q[0].cpha == 1'b0) idx = edges / 2;
      else                      idx = (edges == 0) ? 0 : (edges - 1) / 2;
      if (idx > DATA_W - 1) idx = DATA_W - 1;
      if (sb_q[0].loop)     MISO = MOSI;
      else if (sb_q[0].lsb) MISO = sb_q[0].slv[idx];
      else                  MISO = sb_q[0].slv[DATA_W-1-idx];
    end else begin
      MISO = 1'b0;
    end

    prev_sck  = SCK;
    prev_mosi = MOSI;
    prev_busy = Busy;
  end

  task automatic start_xfer(input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] slv,
                            input logic cpol, input logic cpha, input logic lsb,
                            input int div, input int sel, input logic loop);
    xfer_t e;
    e.tx      = tx;
    e.slv     = loop ? tx : slv;
    e.cpol    = cpol;
    e.cpha    = cpha;
    e.lsb     = lsb;
    e.loop    = loop;
    e.div     = div;
    e.cs_mask = exp_cs_mask(sel);
    sb_q.push_back(e);
    TxData   = tx;
    CPol     = cpol;
    CPha     = cpha;
    LsbFirst = lsb;
    Div      = DIV_W'(div);
    CsSel    = CS_SEL_W'(sel);
    StartTx  = 1'b1;
    @(posedge Clk);
    #1;
    StartTx = 1'b0;
    check("accept_busy", Busy, 1'b1);
    // Config is latched; scrambling the inputs must not disturb the transfer.
    TxData   = DATA_W'($urandom);
    CPol     = 1'($urandom);
    CPha     = 1'($urandom);
    LsbFirst = 1'($urandom);
    Div      = DIV_W'($urandom);
    CsSel    = CS_SEL_W'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge Clk);
      n++;
    end
    check("timeout_pending", sb_q.size(), 0);
    sb_q.delete();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int rises;
    int n;
    int end_c;
    logic prevb;
    int dv;

    Rst      = 1'b1;
    StartTx  = 1'b0;
    TxData   = '0;
    CPol     = 1'b1;
    CPha     = 1'b0;
    LsbFirst = 1'b0;
    Div      = '0;
    CsSel    = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_sck",   SCK, 1'b0);
    check("rst_mosi",  MOSI, 1'b0);
    check("rst_cs",    CS_n, {NUM_CS{1'b1}});
    check("rst_busy",  Busy, 1'b0);
    check("rst_endtx", EndTx, 1'b0);
    check("rst_rx",    RxData, '0);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    check("idle_sck_cpol1", SCK, 1'b1);

    // Mode 0 loopback.
    start_xfer(8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    wait_done(exp_latency(0) + 20);

    // All four modes with a fixed slave word.
    for (int m = 0; m < 4; m++) begin
      CPol = m[1];
      repeat (2) @(posedge Clk);
      #1;
      check("idle_sck", SCK, m[1]);
      start_xfer(8'h3C, 8'hC3, m[1], m[0], 1'b0, 3, 1, 1'b0);
      wait_done(exp_latency(3) + 20);
    end

    // LSB first.
    start_xfer(8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
    wait_done(exp_latency(1) + 20);

    // Chip-select decode, valid and out of range.
    start_xfer(8'h5A, 8'h69, 1'b0, 1'b1, 1'b0, 1, 2, 1'b0);
    wait_done(exp_latency(1) + 20);
    start_xfer(8'h96, 8'h17, 1'b1, 1'b0, 1'b0, 1, 5, 1'b0);
    wait_done(exp_latency(1) + 20);

    // StartTx held high: three back-to-back transfers, one idle cycle between.
    TxData = 8'hC7; CPol = 1'b0; CPha = 1'b1; LsbFirst = 1'b1; Div = 8'd1; CsSel = 3'd3;
    for (int k = 0; k < 3; k++) begin
      xfer_t e;
      e.tx = 8'hC7; e.slv = 8'h4E; e.cpol = 1'b0; e.cpha = 1'b1; e.lsb = 1'b1;
      e.loop = 1'b0; e.div = 1; e.cs_mask = exp_cs_mask(3);
      sb_q.push_back(e);
    end
    StartTx = 1'b1;
    rises = 0;
    n = 0;
    end_c = -1;
    prevb = Busy;
    while (rises < 3 && n < 3000) begin
      @(posedge Clk);
      #1;
      n++;
      if (EndTx) end_c = cyc;
      if (Busy && !prevb) begin
        rises++;
        if (end_c >= 0) check("b2b_gap", cyc - end_c, 2);
      end
      prevb = Busy;
    end
    StartTx = 1'b0;
    check("b2b_starts", rises, 3);
    wait_done(exp_latency(1) + 20);

    // A StartTx pulse mid-transfer is ignored.
    start_xfer(8'h3A, 8'hE1, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0);
    repeat (20) @(posedge Clk);
    #1;
    StartTx = 1'b1;
    @(posedge Clk);
    #1;
    StartTx = 1'b0;
    wait_done(exp_latency(2) + 20);
    repeat (80) @(posedge Clk);
    #1;
    check("no_queued_start", Busy, 1'b0);

    // Reset in cycle 7 of a Div=0 transfer, with StartTx also high.
    start_xfer(8'h5A, 8'h96, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0);
    repeat (6) @(posedge Clk);
    #1;
    Rst = 1'b1;
    StartTx = 1'b1;
    @(posedge Clk);
    #1;
    check("abort_sck",   SCK, 1'b0);
    check("abort_cs",    CS_n, {NUM_CS{1'b1}});
    check("abort_busy",  Busy, 1'b0);
    check("abort_endtx", EndTx, 1'b0);
    Rst = 1'b0;
    StartTx = 1'b0;
    sb_q.delete();
    repeat (40) @(posedge Clk);
    #1;
    start_xfer(8'hE4, 8'h2B, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0);
    wait_done(exp_latency(0) + 20);

    // Maximum divider.
    start_xfer(8'h81, 8'h7E, 1'b1, 1'b1, 1'b0, 255, 0, 1'b0);
    wait_done(exp_latency(255) + 20);

    // Randomised transfers.
    for (int t = 0; t < 20; t++) begin
      dv = int'($urandom_range(0, 6));
      start_xfer(DATA_W'($urandom), DATA_W'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), dv, int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0));
      wait_done(exp_latency(dv) + 20);
      repeat (int'($urandom_range(0, 3))) @(posedge Clk);
      #1;
    end

    check("stray_endtx", stray, 0);
    check("queue_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
